// File: rtl/button_debounce_pkg.sv
// Shared types and default constants for the button debouncer.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        REL_STABLE,
        PRESS_WAIT,
        PRS_STABLE,
        REL_WAIT
    } db_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;   // 10 ms at 50 MHz
    localparam int DEF_LONG_CYCLES     = 50000000; // 1 s at 50 MHz

    // Bits needed to hold 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset)
            ff <= {STAGES{RESET_VAL}};
        else
            ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Synchronized, debounced push button with press/release pulses.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the long-press detector.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pressed,
    output logic press,
    output logic release_pulse,  // `release` is a reserved word
    output logic long_press
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be >= 1");
    end

    localparam logic REL_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int   DBW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LOAD = DBW'(DEBOUNCE_CYCLES - 1);

    logic      btn_sync;
    logic      btn_s;
    db_state_t state;
    logic [DBW-1:0] db_cnt;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (REL_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    assign btn_s = btn_sync ^ REL_LEVEL;

    // Any sample disagreeing with the pending level drops back to the stable
    // state, so a bounce restarts the whole window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= REL_STABLE;
            db_cnt        <= '0;
            pressed       <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                REL_STABLE: begin
                    if (btn_s) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= DB_LOAD;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state  <= REL_STABLE;
                        db_cnt <= '0;
                    end else if (db_cnt == '0) begin
                        state   <= PRS_STABLE;
                        pressed <= 1'b1;
                        press   <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt - DBW'(1);
                    end
                end
                PRS_STABLE: begin
                    if (!btn_s) begin
                        state  <= REL_WAIT;
                        db_cnt <= DB_LOAD;
                    end
                end
                REL_WAIT: begin
                    if (btn_s) begin
                        state  <= PRS_STABLE;
                        db_cnt <= '0;
                    end else if (db_cnt == '0) begin
                        state         <= REL_STABLE;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt - DBW'(1);
                    end
                end
                default: begin
                    state  <= REL_STABLE;
                    db_cnt <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_cnt;

    // Saturating at HOLD_MAX keeps the pulse to once per stable press.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (state == PRS_STABLE) begin
                if (hold_cnt != HOLD_MAX)
                    hold_cnt <= hold_cnt + HW'(1);
                if (hold_cnt == HOLD_LAST)
                    long_press <= 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench: stimulus queues expected pulses with their edge number,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_button_debounce;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LONG_CYCLES     = 10;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk;
    logic reset;
    logic btn_raw;
    logic pressed;
    logic press;
    logic release_pulse;
    logic long_press;

    int   edges;
    int   n_cmp;
    int   n_bad;
    ev_t  sb[$];

    button_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (1),
        .LONG_CYCLES     (LONG_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .pressed       (pressed),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial edges = 0;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Input changes at a negedge where edges==e are first sampled at edge e+1,
    // so the pulse is visible at the negedge where edges == e+1+LAT.
    task automatic push(input int kind, input int cyc);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: got kind %0d at edge %0d required none", kind, edges);
        end else begin
            e = sb.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_edge", edges, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < edges) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_pulse: got nothing at edge %0d required kind %0d", sb[0].cyc, sb[0].kind);
            void'(sb.pop_front());
        end
        if (press === 1'b1 || release_pulse === 1'b1)
            chk("press_release_exclusive", {31'd0, press & release_pulse}, 0);
        if (press === 1'b1) take(K_PRESS);
        if (release_pulse === 1'b1) take(K_RELEASE);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        if (long_press === 1'b1) take(K_LONG);
`else
        chk("long_press_tied_0", {31'd0, long_press}, 0);
`endif
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pressed"}, {31'd0, pressed}, 0);
        chk({tag, "_press"}, {31'd0, press}, 0);
        chk({tag, "_release"}, {31'd0, release_pulse}, 0);
        chk({tag, "_long"}, {31'd0, long_press}, 0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press held 20 cycles, then clean release.
        btn_raw = 1'b0;
        push(K_PRESS, edges + 1 + LAT);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        push(K_LONG, edges + 1 + LAT + LONG_CYCLES);
`endif
        repeat (20) @(negedge clk);
        chk("clean_pressed", {31'd0, pressed}, 1);
        btn_raw = 1'b1;
        push(K_RELEASE, edges + 1 + LAT);
        repeat (10) @(negedge clk);
        chk("clean_released", {31'd0, pressed}, 0);

        // Glitch of 3 cycles is shorter than the window.
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        btn_raw = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_pressed", {31'd0, pressed}, 0);

        // Bounce 0,1,0 then hold; long press 10 cycles after the press.
        btn_raw = 1'b0;
        @(negedge clk);
        btn_raw = 1'b1;
        @(negedge clk);
        btn_raw = 1'b0;
        push(K_PRESS, edges + 1 + LAT);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        push(K_LONG, edges + 1 + LAT + LONG_CYCLES);
`endif
        repeat (LAT + 1 + 15) @(negedge clk);
        chk("bounce_pressed", {31'd0, pressed}, 1);
        btn_raw = 1'b1;
        push(K_RELEASE, edges + 1 + LAT);
        repeat (10) @(negedge clk);
        chk("bounce_released", {31'd0, pressed}, 0);

        // Reset while held in PRS_STABLE; button stays down through reset.
        btn_raw = 1'b0;
        push(K_PRESS, edges + 1 + LAT);
        repeat (10) @(negedge clk);
        chk("pre_reset_pressed", {31'd0, pressed}, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        push(K_PRESS, edges + 1 + LAT);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        push(K_LONG, edges + 1 + LAT + LONG_CYCLES);
`endif
        repeat (20) @(negedge clk);
        chk("post_reset_pressed", {31'd0, pressed}, 1);
        btn_raw = 1'b1;
        push(K_RELEASE, edges + 1 + LAT);
        repeat (10) @(negedge clk);
        chk("post_reset_released", {31'd0, pressed}, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flip-flop depth, legal range 2..4.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable cycles required to accept a new level (10 ms at 50 MHz), minimum 1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means raw button reads 0 when pressed.
REQ-004 SHALL have parameter LONG_CYCLES, default 50000000: pressed cycles before long-press (1 s at 50 MHz), minimum 1.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port btn_raw, input, 1: asynchronous mechanical button input.
REQ-008 SHALL have port pressed, output, 1: debounced level, 1 = pressed (polarity-corrected).
REQ-009 SHALL have port press, output, 1: one-cycle pulse on accepted press; drives the set_led input of the LED blinker.
REQ-010 SHALL have port release, output, 1: one-cycle pulse on accepted release.
REQ-011 SHALL have port long_press, output, 1: one-cycle pulse once per press held LONG_CYCLES.

Function
REQ-012 SHALL pass btn_raw through SYNC_STAGES flip-flops, then invert if ACTIVE_LOW=1, giving btn_s.
REQ-013 SHALL implement FSM states REL_STABLE, PRESS_WAIT, PRS_STABLE, REL_WAIT.
REQ-014 SHALL, in REL_STABLE with btn_s=1, enter PRESS_WAIT and load the debounce counter with DEBOUNCE_CYCLES-1.
REQ-015 SHALL, in PRESS_WAIT, return to REL_STABLE without output change if btn_s=0; else decrement; on btn_s=1 with counter=0, enter PRS_STABLE, set pressed=1, pulse press.
REQ-016 SHALL mirror REQ-014/015 for release: PRS_STABLE -> REL_WAIT -> REL_STABLE, clearing pressed and pulsing release.
REQ-017 SHALL assert pressed and press exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge sampling btn_raw in the pressed level, if it stays there; same latency for release.
REQ-018 SHALL restart the full debounce window on any bounce; glitches shorter than DEBOUNCE_CYCLES SHALL never change pressed.
REQ-019 SHALL never assert press and release in the same cycle; each SHALL be high exactly one cycle per accepted edge.
REQ-020 SHALL size counters at $clog2(max+1) bits and SHALL not wrap; hold counter saturates.

Reset
REQ-021 SHALL, while reset=1 at a clock edge, force FSM to REL_STABLE, counters to 0, synchronizer flops to the released level, and pressed/press/release/long_press to 0.
REQ-022 SHALL, on reset mid-debounce or mid-hold, discard progress; a still-pressed button after reset SHALL be re-debounced and SHALL produce a fresh press pulse.

Configuration
REQ-023 SHALL compile long-press logic only when macro BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
REQ-024 SHALL, with the macro, count cycles in PRS_STABLE from entry and pulse long_press once when the count reaches LONG_CYCLES; leaving PRS_STABLE clears the count.
REQ-025 SHALL, without the macro, keep port long_press, tie it to 0, and instantiate no hold counter.

Structure
REQ-026 SHALL place the FSM state enum and default constants (DEBOUNCE_CYCLES, LONG_CYCLES) in package button_debounce_pkg.
REQ-027 SHALL implement the synchronizer as sub-module sync_chain (parameters STAGES, RESET_VAL).

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1)
REQ-028 SHALL test: btn_raw 1->0 held -> pressed=1 and press pulse at edge 6; release after 20 cycles -> release pulse at edge 6 after change.
REQ-029 SHALL test: btn_raw low 3 cycles then high -> pressed stays 0, no pulses.
REQ-030 SHALL test: bounce 0,1,0 at one-cycle intervals then hold low -> single press 6 edges after final falling edge.
REQ-031 SHALL test: with macro, hold pressed 15 cycles after press -> exactly one long_press, 10 cycles after press; without macro -> long_press constant 0.
REQ-032 SHALL test: reset pulse while in PRS_STABLE with button held -> outputs 0 in reset cycle, fresh press 6 edges after reset deasserts.
